// File: rtl/csr_bank.sv
// csr_bank: contiguous table of CSRs written by CSR instructions and by
// arbitrated hardware ports, each port buffered by a one-entry holding register.
module csr_bank #(
  parameter int unsigned          DataWidth     = 32,
  parameter logic [11:0]          BottomRange   = 12'h000,
  parameter int unsigned          TableSize     = 16,
  parameter int unsigned          NumExtPorts   = 2,
  parameter logic [DataWidth-1:0] WriteMask     = '1,
  parameter logic [DataWidth-1:0] ResetValue    = '0,
  localparam int unsigned         TableSizeBits = $clog2(TableSize)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        csr_enable,
  input  logic [11:0]                                 i_csr_addr,
  input  logic [2:0]                                  csr_op,
  input  logic [4:0]                                  rs1_zimm,
  input  logic [DataWidth-1:0]                        rs1_data,
  output logic                                        csr_hit,
  output logic [DataWidth-1:0]                        csr_rdata,
  input  logic [NumExtPorts-1:0]                      ext_valid,
  output logic [NumExtPorts-1:0]                      ext_ready,
  input  logic [NumExtPorts-1:0][TableSizeBits-1:0]   ext_idx,
  input  logic [NumExtPorts-1:0][DataWidth-1:0]       ext_data,
  output logic [NumExtPorts-1:0]                      ext_err,
  output logic [TableSize-1:0][DataWidth-1:0]         out_table,
  output logic [TableSize-1:0]                        changed
);

  // funct3-style encoding: bit 2 selects the immediate form
  localparam logic [2:0] OpRw  = 3'b001;
  localparam logic [2:0] OpRs  = 3'b010;
  localparam logic [2:0] OpRc  = 3'b011;
  localparam logic [2:0] OpRwi = 3'b101;
  localparam logic [2:0] OpRsi = 3'b110;
  localparam logic [2:0] OpRci = 3'b111;

  logic [11:0]                                csr_off;
  logic [TableSizeBits-1:0]                   csr_idx;
  logic [DataWidth-1:0]                       csr_old;
  logic [DataWidth-1:0]                       csr_src;
  logic [DataWidth-1:0]                       csr_new;
  logic                                       csr_we;
  logic [NumExtPorts-1:0]                     hold_valid;
  logic [NumExtPorts-1:0][TableSizeBits-1:0]  hold_idx;
  logic [NumExtPorts-1:0][DataWidth-1:0]      hold_data;
  logic [NumExtPorts-1:0]                     grant;
  logic [NumExtPorts-1:0]                     ext_in_range;
  logic [TableSize-1:0][DataWidth-1:0]        table_d;

  assign csr_off = i_csr_addr - BottomRange;
  assign csr_idx = csr_off[TableSizeBits-1:0];
  assign csr_hit = csr_enable && (csr_off < 12'(TableSize));
  assign csr_src = csr_op[2] ? DataWidth'(rs1_zimm) : rs1_data;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    csr_old = '0;
    for (int i = 0; i < TableSize; i++) begin
      if (csr_off == 12'(i)) csr_old = out_table[i];
    end
  end

  assign csr_rdata = csr_hit ? csr_old : '0;

  // Set/clear with x0 / zimm==0 is a pure read and must not write.
  always_comb begin
    csr_new = csr_old;
    csr_we  = 1'b0;
    case (csr_op)
      OpRw, OpRwi: begin
        csr_new = csr_src;
        csr_we  = csr_hit;
      end
      OpRs, OpRsi: begin
        csr_new = csr_old | csr_src;
        csr_we  = csr_hit && (rs1_zimm != 5'd0);
      end
      OpRc, OpRci: begin
        csr_new = csr_old & ~csr_src;
        csr_we  = csr_hit && (rs1_zimm != 5'd0);
      end
      default: ;
    endcase
  end

  // A holder commits unless the CSR write or a lower-indexed holder owns its entry.
  always_comb begin
    for (int p = 0; p < NumExtPorts; p++) begin
      grant[p] = hold_valid[p] && !(csr_we && (csr_idx == hold_idx[p]));
      for (int q = 0; q < p; q++) begin
        if (hold_valid[q] && (hold_idx[q] == hold_idx[p])) grant[p] = 1'b0;
      end
      ext_in_range[p] = {1'b0, ext_idx[p]} < (TableSizeBits + 1)'(TableSize);
    end
  end

  assign ext_ready = reset ? '0 : (~hold_valid | grant);

  always_comb begin
    table_d = out_table;
    for (int i = 0; i < TableSize; i++) begin
      for (int p = 0; p < NumExtPorts; p++) begin
        if (grant[p] && (hold_idx[p] == TableSizeBits'(i))) table_d[i] = hold_data[p];
      end
      if (csr_we && (csr_idx == TableSizeBits'(i)))
        table_d[i] = (csr_new & WriteMask) | (out_table[i] & ~WriteMask);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_table  <= {TableSize{ResetValue}};
      changed    <= '0;
      hold_valid <= '0;
      ext_err    <= '0;
    end else begin
      out_table <= table_d;
      for (int i = 0; i < TableSize; i++) changed[i] <= (table_d[i] != out_table[i]);
      for (int p = 0; p < NumExtPorts; p++) begin
        ext_err[p] <= 1'b0;
        if (ext_valid[p] && ext_ready[p]) begin
          hold_valid[p] <= ext_in_range[p];
          ext_err[p]    <= !ext_in_range[p];
        end else if (grant[p]) begin
          hold_valid[p] <= 1'b0;
        end
      end
    end
  end

  // NOTE: holding payload is not reset; it is qualified by hold_valid, which is.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NumExtPorts; p++) begin
      if (ext_valid[p] && ext_ready[p]) begin
        hold_idx[p]  <= ext_idx[p];
        hold_data[p] <= ext_data[p];
      end
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Randomised scoreboard bench for csr_bank: a table-level reference model
// predicts commits and error pulses, and a negedge monitor retires them.
module tb_csr_bank;

  localparam int          DW  = 32;
  localparam logic [11:0] BR  = 12'h7C0;
  localparam int          TS  = 12;
  localparam int          NP  = 3;
  localparam int          TSB = 4;
  localparam logic [DW-1:0] WM = 32'h0000_FFFF;
  localparam logic [DW-1:0] RV = 32'hC000_0000;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         csr_enable;
  logic [11:0]                  csr_addr;
  logic [2:0]                   csr_op;
  logic [4:0]                   rs1_zimm;
  logic [DW-1:0]                rs1_data;
  logic                         csr_hit;
  logic [DW-1:0]                csr_rdata;
  logic [NP-1:0]                ext_valid;
  logic [NP-1:0]                ext_ready;
  logic [NP-1:0][TSB-1:0]       ext_idx;
  logic [NP-1:0][DW-1:0]        ext_data;
  logic [NP-1:0]                ext_err;
  logic [TS-1:0][DW-1:0]        out_table;
  logic [TS-1:0]                changed;

  always #5 clk = ~clk;

  csr_bank #(
    .DataWidth(DW), .BottomRange(BR), .TableSize(TS), .NumExtPorts(NP),
    .WriteMask(WM), .ResetValue(RV)
  ) dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .i_csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
    .csr_hit(csr_hit), .csr_rdata(csr_rdata),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_idx(ext_idx),
    .ext_data(ext_data), .ext_err(ext_err),
    .out_table(out_table), .changed(changed)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] val;
  } change_t;

  change_t       chg_q[$];
  int            err_q[$];
  logic [DW-1:0] m_table [TS];
  bit            m_pv [NP];
  int            m_pi [NP];
  logic [DW-1:0] m_pd [NP];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            mon_on   = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TS; i++) m_table[i] = RV;
    for (int p = 0; p < NP; p++) m_pv[p] = 1'b0;
    chg_q.delete();
    err_q.delete();
  endtask

  task automatic set_idle();
    csr_enable = 1'b0; csr_addr = '0; csr_op = '0; rs1_zimm = '0; rs1_data = '0;
    ext_valid = '0; ext_idx = '0; ext_data = '0;
  endtask

  task automatic set_csr(logic [2:0] op, int off, logic [4:0] z, logic [DW-1:0] d);
    csr_enable = 1'b1; csr_addr = BR + 12'(off); csr_op = op; rs1_zimm = z; rs1_data = d;
  endtask

  task automatic set_ext(int p, int idx, logic [DW-1:0] d);
    ext_valid[p] = 1'b1; ext_idx[p] = TSB'(idx); ext_data[p] = d;
  endtask

  // One clock of stimulus: check combinational outputs, advance the model, clock the DUT.
  task automatic step();
    logic [DW-1:0] nxt [TS];
    bit            win [NP];
    bit            hit, we;
    int            ci;
    logic [DW-1:0] src, res, exp_rd;
    #1;
    ci  = int'(csr_addr) - int'(BR);
    hit = csr_enable && (ci >= 0) && (ci < TS);
    exp_rd = '0;
    if (hit) exp_rd = m_table[ci];
    check("csr_hit", csr_hit, hit);
    check("csr_rdata", csr_rdata, exp_rd);
    src = (csr_op inside {OP_RWI, OP_RSI, OP_RCI}) ? DW'(rs1_zimm) : rs1_data;
    we  = 1'b0;
    res = '0;
    if (hit) begin
      case (csr_op)
        OP_RW, OP_RWI: begin we = 1'b1; res = src; end
        OP_RS, OP_RSI: begin we = (rs1_zimm != 0); res = m_table[ci] | src; end
        OP_RC, OP_RCI: begin we = (rs1_zimm != 0); res = m_table[ci] & ~src; end
        default: ;
      endcase
    end
    for (int i = 0; i < TS; i++) nxt[i] = m_table[i];
    for (int p = 0; p < NP; p++) begin
      win[p] = m_pv[p] && !(we && (m_pi[p] == ci));
      for (int q = 0; q < p; q++)
        if (m_pv[q] && (m_pi[q] == m_pi[p])) win[p] = 1'b0;
      check($sformatf("ext_ready[%0d]", p), ext_ready[p], !m_pv[p] || win[p]);
      if (win[p]) nxt[m_pi[p]] = m_pd[p];
    end
    if (we) nxt[ci] = (res & WM) | (m_table[ci] & ~WM);
    for (int i = 0; i < TS; i++)
      if (nxt[i] !== m_table[i]) chg_q.push_back('{i, nxt[i]});
    for (int p = 0; p < NP; p++) begin
      if (ext_valid[p] && (!m_pv[p] || win[p])) begin
        if (int'(ext_idx[p]) < TS) begin
          m_pv[p] = 1'b1; m_pi[p] = int'(ext_idx[p]); m_pd[p] = ext_data[p];
        end else begin
          m_pv[p] = 1'b0;
          err_q.push_back(p);
        end
      end else if (win[p]) begin
        m_pv[p] = 1'b0;
      end
    end
    for (int i = 0; i < TS; i++) m_table[i] = nxt[i];
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < TS; i++) check($sformatf("reset_entry[%0d]", i), out_table[i], RV);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", ext_ready, {NP{1'b1}});
  endtask

  // Monitor: retire predicted change pulses and error pulses, compare table state.
  always @(negedge clk) begin
    change_t c;
    int      ep;
    if (mon_on) begin
      if (reset) begin
        check("changed_in_reset", changed, '0);
        check("ext_err_in_reset", ext_err, '0);
        check("ext_ready_in_reset", ext_ready, '0);
      end else begin
        for (int i = 0; i < TS; i++) begin
          if (changed[i]) begin
            if (chg_q.size() == 0) check($sformatf("unexpected_change[%0d]", i), changed[i], 1'b0);
            else begin
              c = chg_q.pop_front();
              check("change_idx", i, c.idx);
              check($sformatf("change_val[%0d]", i), out_table[i], c.val);
            end
          end
        end
        for (int p = 0; p < NP; p++) begin
          if (ext_err[p]) begin
            if (err_q.size() == 0) check($sformatf("unexpected_err[%0d]", p), ext_err[p], 1'b0);
            else begin
              ep = err_q.pop_front();
              check("err_port", p, ep);
            end
          end
        end
        for (int i = 0; i < TS; i++) check($sformatf("table[%0d]", i), out_table[i], m_table[i]);
      end
    end
  end

  initial begin
    logic [DW-1:0] d0, d1;
    set_idle();
    model_reset();
    #2 reset = 1'b1;
    #1 mon_on = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < TS; i++) check($sformatf("init_entry[%0d]", i), out_table[i], RV);
    check("init_ready", ext_ready, {NP{1'b1}});
    check("init_changed", changed, '0);

    // Masked-off bits never pulse; unmasked bits do; set with x0 is a read.
    set_idle(); set_csr(OP_RW, 3, 5'd5, 32'hA5A5_0000); step();
    check("rw_masked_entry3", out_table[3], 32'hC000_0000);
    check("rw_masked_no_pulse", changed[3], 1'b0);
    set_idle(); set_csr(OP_RW, 3, 5'd5, 32'h0000_1234); step();
    check("rw_entry3", out_table[3], 32'hC000_1234);
    check("rw_pulse", changed[3], 1'b1);
    set_idle(); set_csr(OP_RS, 3, 5'd0, 32'hFFFF_FFFF); step();
    check("rs_x0_entry3", out_table[3], 32'hC000_1234);
    check("rs_x0_no_pulse", changed[3], 1'b0);

    set_idle(); set_csr(OP_RW, 0, 5'd7, 32'hFFFF_FFFF); step();
    check("rw_mask_entry0", out_table[0], 32'hC000_FFFF);
    set_idle(); set_csr(OP_RCI, 0, 5'h1F, 32'h0); step();
    check("rci_entry0", out_table[0], 32'hC000_FFE0);

    // Two ports collide on entry 5.
    d0 = 32'h1111_0005; d1 = 32'h2222_0005;
    set_idle(); set_ext(0, 5, d0); set_ext(1, 5, d1); step();
    set_idle();
    check("collide_ready1_low", ext_ready[1], 1'b0);
    check("collide_ready0_high", ext_ready[0], 1'b1);
    step();
    check("collide_port0_first", out_table[5], d0);
    step();
    check("collide_port1_last", out_table[5], d1);

    // CSR beats a held ext write on entry 2.
    set_idle(); set_ext(0, 2, 32'hDEAD_BEEF); step();
    set_idle(); set_csr(OP_RW, 2, 5'd1, 32'h0000_4321); step();
    check("csr_first_entry2", out_table[2], 32'hC000_4321);
    set_idle(); step();
    check("ext_next_entry2", out_table[2], 32'hDEAD_BEEF);

    // Out-of-range index is dropped with an error pulse.
    set_idle(); set_ext(1, TS, 32'h5555_5555); step();
    check("oor_err_pulse", ext_err, 3'b010);
    set_idle(); step();
    check("oor_err_cleared", ext_err, 3'b000);

    // All three ports on one entry: retire in port order.
    set_idle(); set_ext(0, 7, 32'hA); set_ext(1, 7, 32'hB); set_ext(2, 7, 32'hC); step();
    set_idle(); repeat (3) step();
    check("three_way_final", out_table[7], 32'hC);

    // Held request stalled by CSR traffic is discarded by reset.
    set_idle(); set_ext(0, 4, 32'h7777_7777); step();
    for (int n = 0; n < 3; n++) begin
      set_idle(); set_csr(OP_RW, 4, 5'd1, $urandom); step();
      check("stalled_ready0", ext_ready[0], 1'b0);
    end
    do_reset();
    set_idle(); repeat (3) step();
    check("reset_drop_entry4", out_table[4], RV);

    for (int n = 0; n < 3000; n++) begin
      int off;
      set_idle();
      off = int'($urandom_range(0, TS + 3)) - 2;
      csr_addr = BR + 12'(off);
      csr_enable = $urandom_range(0, 1) == 1;
      csr_op = 3'($urandom_range(0, 7));
      rs1_zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1_data = $urandom;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) != 0)
          set_ext(p, ($urandom_range(0, 7) == 0) ? int'($urandom_range(TS, 15))
                                                 : int'($urandom_range(0, 5)), $urandom);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    set_idle(); repeat (4) step();
    check("changes_drained", chg_q.size(), 0);
    check("errors_drained", err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
